// File: rtl/switch_word_assembler_pkg.sv
// switch_word_assembler_pkg: shared FSM encodings and debounce defaults for the switch word path
package switch_word_assembler_pkg;

    typedef enum logic {
        ST_WAIT_HI = 1'b0,
        ST_WAIT_LO = 1'b1
    } state_e;

    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 1_000_000;

endpackage

// File: rtl/switch_word_assembler_button_debounce.sv
// button_debounce: synchronizes a raw button, debounces it and emits one strobe per press
module button_debounce
    import switch_word_assembler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic strobe
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          prev_q;
    logic          strobe_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the stability count
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                db_d = ~db_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            prev_q   <= db_q;
            strobe_q <= db_q & ~prev_q;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/switch_word_assembler.sv
// switch_word_assembler: builds an N-bit word from two button-committed N/2-bit switch entries
module switch_word_assembler
    import switch_word_assembler_pkg::*;
#(
    parameter int N               = 32,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N/2-1:0] sw_data,
    input  logic           load_btn,
    input  logic           clr_btn,
    output logic [N-1:0]   word_data,
    output logic           word_valid,
    output logic           half_sel
);

    logic           load_stb, clr_stb;
    state_e         state_q, state_d;
    logic [N/2-1:0] hi_buf_q, hi_buf_d;
    logic [N-1:0]   word_q, word_d;
    logic           valid_q, valid_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(clk), .rst(rst), .btn_raw(load_btn), .strobe(load_stb)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .rst(rst), .btn_raw(clr_btn), .strobe(clr_stb)
    );

    // Clear outranks load so a simultaneous press never completes a word
    always_comb begin
        state_d  = state_q;
        hi_buf_d = hi_buf_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        if (clr_stb) begin
            state_d = ST_WAIT_HI;
        end else if (load_stb) begin
            if (state_q == ST_WAIT_HI) begin
                hi_buf_d = sw_data;
                state_d  = ST_WAIT_LO;
            end else begin
                word_d  = {hi_buf_q, sw_data};
                valid_d = 1'b1;
                state_d = ST_WAIT_HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT_HI;
            hi_buf_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_buf_q <= hi_buf_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
        end
    end

    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign half_sel   = (state_q == ST_WAIT_LO);

endmodule

// File: tb/tb_switch_word_assembler.sv
// tb_switch_word_assembler: directed stimulus checked every cycle against a window-based button model
module tb_switch_word_assembler;

    localparam int N = 32;
    localparam int D = 4;
    localparam int H = N / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_btn = 1'b0;
    logic         clr_btn = 1'b0;
    logic [H-1:0] sw_data = '0;
    logic [N-1:0] word_data;
    logic         word_valid;
    logic         half_sel;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    switch_word_assembler #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_data(sw_data), .load_btn(load_btn), .clr_btn(clr_btn),
        .word_data(word_data), .word_valid(word_valid), .half_sel(half_sel)
    );

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // A button level is accepted once the last D synchronized samples all disagree with it
    initial begin : mdl
        bit           ms1[2], ms2[2], mlv[2], mlp[2], mst[2];
        bit [D-1:0]   mw[2];
        bit           raw[2];
        bit           cmp, nl, ls, cs, r;
        bit           e_half, e_valid;
        bit [H-1:0]   e_hi, s;
        bit [N-1:0]   e_word;
        e_half = 0; e_valid = 0; e_hi = '0; e_word = '0;
        forever begin
            @(posedge clk);
            r = rst; raw[0] = load_btn; raw[1] = clr_btn; s = sw_data;
            if (r) begin
                for (int b = 0; b < 2; b++) begin
                    ms1[b] = 0; ms2[b] = 0; mlv[b] = 0; mlp[b] = 0; mst[b] = 0; mw[b] = '0;
                end
                e_half = 0; e_valid = 0; e_hi = '0; e_word = '0;
            end else begin
                ls = mst[0];
                cs = mst[1];
                for (int b = 0; b < 2; b++) begin
                    cmp = ms2[b];
                    ms2[b] = ms1[b];
                    ms1[b] = raw[b];
                    mw[b] = {mw[b][D-2:0], cmp};
                    nl = (mw[b] == (mlv[b] ? {D{1'b0}} : {D{1'b1}})) ? ~mlv[b] : mlv[b];
                    mst[b] = mlv[b] & ~mlp[b];
                    mlp[b] = mlv[b];
                    mlv[b] = nl;
                end
                e_valid = 0;
                if (cs) e_half = 0;
                else if (ls) begin
                    if (!e_half) begin
                        e_hi = s;
                        e_half = 1;
                    end else begin
                        e_word = {e_hi, s};
                        e_valid = 1;
                        e_half = 0;
                    end
                end
            end
            #1;
            check("word_data", word_data, e_word);
            check("word_valid", {31'b0, word_valid}, {31'b0, e_valid});
            check("half_sel", {31'b0, half_sel}, {31'b0, e_half});
            if (word_valid === 1'b1) vcount++;
        end
    end

    task automatic press_load(input logic [H-1:0] v, input int n);
        @(negedge clk);
        sw_data = v;
        load_btn = 1'b1;
        repeat (n) @(negedge clk);
        load_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic press_clr(input int n);
        @(negedge clk);
        clr_btn = 1'b1;
        repeat (n) @(negedge clk);
        clr_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int v0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_word", word_data, 32'h0);
        check("rst_half", {31'b0, half_sel}, 32'h0);
        check("rst_nopulse", vcount, 0);

        @(negedge clk);
        sw_data = 16'hDEAD;
        load_btn = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("half_edge7", {31'b0, half_sel}, 32'h0);
        @(posedge clk);
        #1 check("half_edge8", {31'b0, half_sel}, 32'h1);
        repeat (2) @(negedge clk);
        load_btn = 1'b0;
        repeat (12) @(negedge clk);
        v0 = vcount;
        press_load(16'hBEEF, 10);
        check("full_word", word_data, 32'hDEADBEEF);
        check("full_pulses", vcount - v0, 1);
        check("full_half", {31'b0, half_sel}, 32'h0);

        v0 = vcount;
        repeat (4) begin
            @(negedge clk);
            load_btn = 1'b1;
            repeat (3) @(negedge clk);
            load_btn = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_half", {31'b0, half_sel}, 32'h0);
        check("glitch_pulses", vcount - v0, 0);

        press_load(16'h1234, 10);
        check("clr_pre_half", {31'b0, half_sel}, 32'h1);
        press_clr(10);
        check("clr_half", {31'b0, half_sel}, 32'h0);
        check("clr_word", word_data, 32'hDEADBEEF);
        check("clr_pulses", vcount - v0, 0);

        press_load(16'h5555, 10);
        check("sim_pre_half", {31'b0, half_sel}, 32'h1);
        @(negedge clk);
        load_btn = 1'b1;
        clr_btn = 1'b1;
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (12) @(negedge clk);
        check("sim_half", {31'b0, half_sel}, 32'h0);
        check("sim_word", word_data, 32'hDEADBEEF);
        check("sim_pulses", vcount - v0, 0);

        press_load(16'h7777, 10);
        check("rmid_pre_half", {31'b0, half_sel}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rmid_half", {31'b0, half_sel}, 32'h0);
        check("rmid_word", word_data, 32'h0);
        v0 = vcount;
        press_load(16'hCAFE, 10);
        press_load(16'h0001, 10);
        check("rmid_final", word_data, 32'hCAFE0001);
        check("rmid_pulses", vcount - v0, 1);
        check("rmid_final_half", {31'b0, half_sel}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
